bpsk_demodulator: RTL and testbench

BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

---
 rtl/bpsk_demodulator.sv | 108 ++++++++++
 tb/tb_bpsk_demodulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: square-reference correlation per symbol, MSB-first frame assembly into q with a one-cycle dv pulse.
// Latency: q/dv update on the edge accepting a frame's last sample; no backpressure, samples are taken whenever en=1.
// Optional BPSK_DEMODULATOR_MARGIN_EN adds output margin = min |acc| over the frame's decisions.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                                           clk,
  input  logic                                           arst,
  input  logic                                           en,
  input  logic signed [SAMPLE_WIDTH-1:0]                 signal_in,
  output logic        [DATA_WIDTH-1:0]                   q,
  output logic                                           dv
`ifdef BPSK_DEMODULATOR_MARGIN_EN
  ,
  output logic [SAMPLE_WIDTH+$clog2(SAMPLE_NUMBER):0]    margin
`endif
);

  localparam int ACC_W = SAMPLE_WIDTH + $clog2(SAMPLE_NUMBER) + 1;
  localparam int SW    = $clog2(SAMPLE_NUMBER);
  localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [SW-1:0]           s;
  logic [BW-1:0]           b;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_WIDTH-1:0]   frame;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    bit_dec;
  logic [DATA_WIDTH-1:0]   frame_next;
  logic                    last_sample;
  logic                    last_symbol;

  always_comb begin
    sample_ext  = {{(ACC_W-SAMPLE_WIDTH){signal_in[SAMPLE_WIDTH-1]}}, signal_in};
    // s MSB set means the second half of the carrier period, where the reference is -1
    acc_sum     = s[SW-1] ? (acc - sample_ext) : (acc + sample_ext);
    bit_dec     = ~acc_sum[ACC_W-1];
    frame_next  = DATA_WIDTH'({frame, bit_dec});
    last_sample = (s == SW'(SAMPLE_NUMBER - 1));
    last_symbol = (b == BW'(DATA_WIDTH - 1));
  end

`ifdef BPSK_DEMODULATOR_MARGIN_EN
  logic [ACC_W-1:0] abs_acc;
  logic [ACC_W-1:0] min_run;
  logic [ACC_W-1:0] min_next;

  always_comb begin
    abs_acc  = acc_sum[ACC_W-1] ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
    min_next = ((b == '0) || (abs_acc < min_run)) ? abs_acc : min_run;
  end
`endif

  always_ff @(posedge clk) begin
    if (!arst) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      acc   <= '0;
      frame <= '0;
      q     <= '0;
      dv    <= 1'b0;
`ifdef BPSK_DEMODULATOR_MARGIN_EN
      min_run <= '0;
      margin  <= '0;
`endif
    end else begin
      dv <= 1'b0;
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
      // the first sample seen in IDLE is already sample 0, so the datapath runs in both states
      if (en) begin
        if (last_sample) begin
          s     <= '0;
          acc   <= '0;
          frame <= frame_next;
`ifdef BPSK_DEMODULATOR_MARGIN_EN
          min_run <= min_next;
`endif
          if (last_symbol) begin
            b  <= '0;
            q  <= frame_next;
            dv <= 1'b1;
`ifdef BPSK_DEMODULATOR_MARGIN_EN
            margin <= min_next;
`endif
          end else begin
            b <= b + 1'b1;
          end
        end else begin
          s   <= s + 1'b1;
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Bench for bpsk_demodulator: table of frames driven through a scoreboard of expected q / dv cycle,
// plus reset-at-start, hold-between-frames and reset-mid-frame sequences.
module tb_bpsk_demodulator;
  localparam int SN = 256;
  localparam int SW = 12;
  localparam int DW = 12;
  localparam int AW = SW + $clog2(SN) + 1;

  logic                 clk = 1'b0;
  logic                 arst;
  logic                 en;
  logic signed [SW-1:0] signal_in;
  logic [DW-1:0]        q;
  logic                 dv;
`ifdef BPSK_DEMODULATOR_MARGIN_EN
  logic [AW-1:0]        margin;
`endif

  bpsk_demodulator #(.SAMPLE_NUMBER(SN), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .arst(arst),
    .en(en),
    .signal_in(signal_in),
    .q(q),
    .dv(dv)
`ifdef BPSK_DEMODULATOR_MARGIN_EN
    ,
    .margin(margin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    int            a1;
    int            a2;
    bit            fixed;
    int            gap;
    logic [DW-1:0] exp_q;
  } vec_t;

  typedef struct {
    logic [DW-1:0] q;
    int            cyc;
    longint        margin;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (dv) begin
      if (sb.size() == 0) begin
        check("spurious_dv", 1, 0);
      end else begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("dv_cycle", cyc, e.cyc);
`ifdef BPSK_DEMODULATOR_MARGIN_EN
        check("margin", margin, e.margin);
`endif
      end
    end
  end

  // Drives one frame (bit 1 = a1 then a2, bit 0 = negated unless fixed); stops after stop_at samples if >= 0.
  task automatic drive_frame(input vec_t v, input int stop_at, input bit push);
    exp_t   e;
    longint mn;
    longint acc;
    int     n;
    int     v1;
    int     v2;
    mn = -1;
    n  = 0;
    for (int k = 0; k < DW; k++) begin
      if (v.fixed || v.word[DW-1-k]) begin
        v1 = v.a1;
        v2 = v.a2;
      end else begin
        v1 = -v.a1;
        v2 = -v.a2;
      end
      acc = longint'(SN / 2) * longint'(v1 - v2);
      if (acc < 0) acc = -acc;
      if (mn < 0 || acc < mn) mn = acc;
      for (int i = 0; i < SN; i++) begin
        if (n == stop_at) return;
        @(negedge clk);
        en        = 1'b1;
        signal_in = SW'((i < SN / 2) ? v1 : v2);
        if (push && k == DW - 1 && i == SN - 1) begin
          e.q      = v.exp_q;
          e.cyc    = cyc + 1;
          e.margin = mn;
          sb.push_back(e);
        end
        n++;
        repeat (v.gap) begin
          @(negedge clk);
          en        = 1'b0;
          signal_in = SW'($urandom);
        end
      end
    end
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v3c3;

    vecs[0] = '{12'hA5C,  1000, -1000, 1'b0, 0, 12'hA5C};
    vecs[1] = '{12'hA5C,  1000, -1000, 1'b0, 1, 12'hA5C};
    vecs[2] = '{12'h000,     0,     0, 1'b0, 0, 12'hFFF};
    vecs[3] = '{12'h000, -2048,  2047, 1'b1, 0, 12'h000};
    vecs[4] = '{12'h001,     1,    -1, 1'b0, 0, 12'h001};
    vecs[5] = '{12'hFFF,  2047, -2047, 1'b0, 0, 12'hFFF};
    vecs[6] = '{12'h3C3,   500,  -500, 1'b0, 2, 12'h3C3};
    v3c3    = '{12'h3C3,   700,  -700, 1'b0, 0, 12'h3C3};

    arst      = 1'b0;
    en        = 1'b1;
    signal_in = 12'sd100;
    repeat (2) @(negedge clk);
    check("reset_q", q, 0);
    check("reset_dv", dv, 0);
    arst = 1'b1;
    en   = 1'b0;

    for (int t = 0; t < 7; t++) drive_frame(vecs[t], -1, 1'b1);
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("q_hold", q, 12'h3C3);
    check("dv_idle", dv, 0);

    drive_frame(v3c3, 1500, 1'b0);
    @(negedge clk);
    arst      = 1'b0;
    en        = 1'b1;
    signal_in = 12'sd300;
    repeat (2) @(negedge clk);
    check("midreset_q", q, 0);
    check("midreset_dv", dv, 0);
    arst = 1'b1;
    en   = 1'b0;

    drive_frame(v3c3, -1, 1'b1);
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("missing_dv", sb.size(), 0);
    check("final_q", q, 12'h3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
